// File: rtl/ama_riscv_csr_dbg_arb_pkg.sv
// rtl/ama_riscv_csr_dbg_arb_pkg.sv - shared types for the CSR port arbiter
package ama_riscv_csr_dbg_arb_pkg;

  typedef struct packed {
    logic       en;
    logic       re;
    logic       we;
    logic [1:0] op;
    logic       ui;
  } csr_ctrl_t;

  // op encodings follow funct3[1:0] of the CSR instructions
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  typedef enum logic [1:0] {DBG_RD, DBG_RW, DBG_RS, DBG_RC} dbg_csr_op_t;

  typedef enum logic [2:0] {
    ARB_IDLE, ARB_ACC, ARB_H1, ARB_LO, ARB_H2, ARB_RSP
  } arb_state_t;

  // Plain read: set-with-zero semantics, write enable kept low
  localparam csr_ctrl_t CSR_CTRL_RD = '{en: 1'b1, re: 1'b1, we: 1'b0,
                                        op: CSR_OP_RS, ui: 1'b0};

  function automatic logic [1:0] dbg_to_csr_op(input dbg_csr_op_t op);
    case (op)
      DBG_RW:  return CSR_OP_RW;
      DBG_RC:  return CSR_OP_RC;
      default: return CSR_OP_RS;
    endcase
  endfunction

endpackage

// File: rtl/csr_starve_ctr.sv
// rtl/csr_starve_ctr.sv - debug starvation counter and forced core stall
module csr_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_pending_i,
  input  logic core_req_i,
  output logic core_stall_o,
  output logic dbg_slot_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign core_stall_o = dbg_pending_i & core_req_i & (cnt_q == LIMIT);
  assign dbg_slot_o   = dbg_pending_i & (~core_req_i | core_stall_o);

  // Only counts while debug waits, so it can never pass LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (dbg_slot_o)
      cnt_d = '0;
    else if (dbg_pending_i && core_req_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ama_riscv_csr_dbg_arb.sv
// rtl/ama_riscv_csr_dbg_arb.sv - CSR port arbiter between core and debug
// Core has priority; debug runs single accesses or tear-free wide reads.
module ama_riscv_csr_dbg_arb
  import ama_riscv_csr_dbg_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [11:0] HI_OFFSET    = 12'h080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_csr_req,
  input  csr_ctrl_t   core_ctrl,
  input  logic [11:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  dbg_csr_op_t dbg_req_op,
  input  logic        dbg_req_wide,
  input  logic [11:0] dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic [63:0] dbg_rsp_data,
  output logic        dbg_rsp_err,
  output csr_ctrl_t   csr_ctrl,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  arb_state_t    state_q, state_d;
  dbg_csr_op_t   op_q, op_d;
  logic [11:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   hi0_q, hi0_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [RW-1:0] retry_q, retry_d;

  logic          dbg_pending;
  logic          dbg_slot;
  csr_ctrl_t     dbg_ctrl;
  logic [11:0]   dbg_addr;
  logic [31:0]   dbg_wdata;
  logic [11:0]   hi_addr;

  assign dbg_pending = (state_q == ARB_ACC) || (state_q == ARB_H1) ||
                       (state_q == ARB_LO)  || (state_q == ARB_H2);
  assign hi_addr     = addr_q + HI_OFFSET;

  csr_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk           (clk),
    .rst_n         (rst_n),
    .dbg_pending_i (dbg_pending),
    .core_req_i    (core_csr_req),
    .core_stall_o  (core_stall),
    .dbg_slot_o    (dbg_slot)
  );

  assign dbg_req_ready = rst_n & (state_q == ARB_IDLE);
  assign dbg_rsp_valid = (state_q == ARB_RSP);
  assign dbg_rsp_data  = data_q;
  assign dbg_rsp_err   = err_q;

  // Port is quiet in reset even if the core keeps presenting a request
  assign csr_ctrl  = !rst_n ? '0 : (dbg_slot ? dbg_ctrl : core_ctrl);
  assign csr_addr  = dbg_slot ? dbg_addr  : core_addr;
  assign csr_wdata = dbg_slot ? dbg_wdata : core_wdata;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hi0_d     = hi0_q;
    data_d    = data_q;
    err_d     = err_q;
    retry_d   = retry_q;
    dbg_ctrl  = '0;
    dbg_addr  = addr_q;
    dbg_wdata = '0;
    case (state_q)
      ARB_IDLE: begin
        if (dbg_req_valid && dbg_req_ready) begin
          op_d    = dbg_req_op;
          addr_d  = dbg_req_addr;
          wdata_d = dbg_req_wdata;
          data_d  = '0;
          err_d   = 1'b0;
          state_d = (dbg_req_wide && dbg_req_op == DBG_RD) ? ARB_H1 : ARB_ACC;
        end
      end
      ARB_ACC: begin
        dbg_ctrl.en = 1'b1;
        dbg_ctrl.re = 1'b1;
        dbg_ctrl.we = (op_q != DBG_RD);
        dbg_ctrl.op = dbg_to_csr_op(op_q);
        dbg_wdata   = wdata_q;
        if (dbg_slot) begin
          data_d  = {32'h0, csr_rdata};
          state_d = ARB_RSP;
        end
      end
      ARB_H1: begin
        dbg_ctrl = CSR_CTRL_RD;
        dbg_addr = hi_addr;
        if (dbg_slot) begin
          hi0_d   = csr_rdata;
          state_d = ARB_LO;
        end
      end
      ARB_LO: begin
        dbg_ctrl = CSR_CTRL_RD;
        if (dbg_slot) begin
          data_d[31:0] = csr_rdata;
          state_d      = ARB_H2;
        end
      end
      ARB_H2: begin
        dbg_ctrl = CSR_CTRL_RD;
        dbg_addr = hi_addr;
        if (dbg_slot) begin
          if (csr_rdata == hi0_q) begin
            data_d[63:32] = csr_rdata;
            state_d       = ARB_RSP;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            hi0_d   = csr_rdata;
            state_d = ARB_LO;
          end else begin
            err_d         = 1'b1;
            data_d[63:32] = csr_rdata;
            state_d       = ARB_RSP;
          end
        end
      end
      ARB_RSP: begin
        if (dbg_rsp_ready) begin
          retry_d = '0;
          err_d   = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      op_q    <= DBG_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      hi0_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hi0_q   <= hi0_d;
      data_q  <= data_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_csr_dbg_arb.sv
// tb/tb_ama_riscv_csr_dbg_arb.sv - directed bench for the CSR port arbiter
module tb_ama_riscv_csr_dbg_arb;
  import ama_riscv_csr_dbg_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        core_csr_req;
  csr_ctrl_t   core_ctrl;
  logic [11:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  dbg_csr_op_t dbg_req_op;
  logic        dbg_req_wide;
  logic [11:0] dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [63:0] dbg_rsp_data;
  logic        dbg_rsp_err;
  csr_ctrl_t   csr_ctrl;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  ama_riscv_csr_dbg_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_csr_req  (core_csr_req),
    .core_ctrl     (core_ctrl),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_stall    (core_stall),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_op    (dbg_req_op),
    .dbg_req_wide  (dbg_req_wide),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_ready (dbg_rsp_ready),
    .dbg_rsp_data  (dbg_rsp_data),
    .dbg_rsp_err   (dbg_rsp_err),
    .csr_ctrl      (csr_ctrl),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: 0xB00/0xB80 is a free-running 64-bit cycle counter,
  // 0xC80 changes on every access, everything else is plain storage.
  logic [31:0] mem [0:4095];
  logic [63:0] cyc = 64'h0;
  logic        cyc_load;
  logic [63:0] cyc_val;
  logic [31:0] hc = 32'h100;

  always_comb begin
    case (csr_addr)
      12'hB00: csr_rdata = cyc[31:0];
      12'hB80: csr_rdata = cyc[63:32];
      12'hC80: csr_rdata = hc;
      default: csr_rdata = mem[csr_addr];
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc_load ? cyc_val : cyc + 64'd1;
    if (csr_ctrl.en && csr_addr == 12'hC80) hc <= hc + 32'd1;
    if (csr_ctrl.en && csr_ctrl.we) begin
      case (csr_ctrl.op)
        CSR_OP_RW: mem[csr_addr] <= csr_wdata;
        CSR_OP_RS: mem[csr_addr] <= csr_rdata | csr_wdata;
        CSR_OP_RC: mem[csr_addr] <= csr_rdata & ~csr_wdata;
        default:   ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic dbg_issue(input dbg_csr_op_t op, input logic wide,
                           input logic [11:0] addr, input logic [31:0] wd);
    int guard;
    dbg_req_valid = 1'b1;
    dbg_req_op    = op;
    dbg_req_wide  = wide;
    dbg_req_addr  = addr;
    dbg_req_wdata = wd;
    guard = 0;
    while (!dbg_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("req_accept", dbg_req_ready, 1'b1);
    @(posedge clk);
    #1;
    dbg_req_valid = 1'b0;
    cyc_load      = 1'b0;
  endtask

  task automatic dbg_finish(output logic [63:0] data, output logic err, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dbg_rsp_valid && lat < 100);
    check_eq("rsp_seen", dbg_rsp_valid, 1'b1);
    data = dbg_rsp_data;
    err  = dbg_rsp_err;
    dbg_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    dbg_rsp_ready = 1'b0;
    check_eq("rsp_drop", dbg_rsp_valid, 1'b0);
    @(negedge clk);
  endtask

  task automatic dbg_txn(input dbg_csr_op_t op, input logic wide, input logic [11:0] addr,
                         input logic [31:0] wd, output logic [63:0] data,
                         output logic err, output int lat);
    dbg_issue(op, wide, addr, wd);
    dbg_finish(data, err, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        e;
    int          lat;

    rst_n         = 1'b0;
    core_csr_req  = 1'b1;
    core_ctrl     = '{en: 1'b1, re: 1'b1, we: 1'b1, op: CSR_OP_RW, ui: 1'b0};
    core_addr     = 12'h305;
    core_wdata    = 32'h55;
    dbg_req_valid = 1'b0;
    dbg_req_op    = DBG_RD;
    dbg_req_wide  = 1'b0;
    dbg_req_addr  = '0;
    dbg_req_wdata = '0;
    dbg_rsp_ready = 1'b0;
    cyc_load      = 1'b0;
    cyc_val       = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", dbg_req_ready, 1'b0);
    check_eq("rst_rsp_valid", dbg_rsp_valid, 1'b0);
    check_eq("rst_rsp_data",  dbg_rsp_data, 64'h0);
    check_eq("rst_rsp_err",   dbg_rsp_err, 1'b0);
    check_eq("rst_core_stall", core_stall, 1'b0);
    check_eq("rst_csr_ctrl",  csr_ctrl, '0);

    core_csr_req = 1'b0;
    core_ctrl    = '0;
    rst_n        = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", dbg_req_ready, 1'b1);

    // single write then read back through one slot each
    dbg_txn(DBG_RW, 1'b0, 12'h340, 32'h1234, d, e, lat);
    check_eq("rw_lat", lat, 2);
    dbg_txn(DBG_RD, 1'b0, 12'h340, 32'hFFFF_FFFF, d, e, lat);
    check_eq("rd_data", d, 64'h0000_0000_0000_1234);
    check_eq("rd_lat", lat, 2);
    check_eq("rd_err", e, 1'b0);
    check_eq("rd_no_write", mem[12'h340], 32'h1234);

    // core hammers the port; the ninth cycle is stolen for debug
    core_csr_req = 1'b1;
    core_ctrl    = '{en: 1'b1, re: 1'b1, we: 1'b0, op: CSR_OP_RS, ui: 1'b0};
    core_addr    = 12'h341;
    core_wdata   = 32'h0;
    dbg_issue(DBG_RW, 1'b0, 12'h340, 32'hA5A5);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall_c%0d", i), core_stall, (i == 9));
      if (i == 9) begin
        check_eq("forced_addr", csr_addr, 12'h340);
        check_eq("forced_we", csr_ctrl.we, 1'b1);
        check_eq("forced_ui", csr_ctrl.ui, 1'b0);
      end
    end
    core_csr_req = 1'b0;
    core_ctrl    = '0;
    dbg_finish(d, e, lat);
    check_eq("starve_old", d, 64'h1234);
    check_eq("starve_write", mem[12'h340], 32'hA5A5);

    // read-set returns old value; the follow-up read shows the OR
    dbg_txn(DBG_RW, 1'b0, 12'h340, 32'hF0, d, e, lat);
    dbg_txn(DBG_RS, 1'b0, 12'h340, 32'h0F, d, e, lat);
    check_eq("rs_old", d, 64'hF0);
    dbg_txn(DBG_RD, 1'b0, 12'h340, 32'h0, d, e, lat);
    check_eq("rs_new", d, 64'hFF);

    // wide flag with a non-read op is a single access
    dbg_txn(DBG_RC, 1'b1, 12'h340, 32'h0F, d, e, lat);
    check_eq("wide_rc_data", d, 64'hFF);
    check_eq("wide_rc_lat", lat, 2);
    check_eq("wide_rc_mem", mem[12'h340], 32'hF0);

    // carry between H1 and H2: hi 5 then 6 -> one retry, value {6, 1}
    cyc_val  = 64'h5_FFFF_FFFE;
    cyc_load = 1'b1;
    dbg_txn(DBG_RD, 1'b1, 12'hB00, 32'h0, d, e, lat);
    check_eq("carry_data", d, 64'h0000_0006_0000_0001);
    check_eq("carry_err", e, 1'b0);
    check_eq("carry_lat", lat, 6);

    // high half changes on every sample: 3 retries then error
    dbg_txn(DBG_RW, 1'b0, 12'hC00, 32'hDEAD_BEEF, d, e, lat);
    dbg_txn(DBG_RD, 1'b1, 12'hC00, 32'h0, d, e, lat);
    check_eq("unstable_data", d, 64'h0000_0104_DEAD_BEEF);
    check_eq("unstable_err", e, 1'b1);
    check_eq("unstable_samples", hc, 32'h105);

    // high address wraps around the 12-bit space
    dbg_txn(DBG_RW, 1'b0, 12'hFC0, 32'h55, d, e, lat);
    dbg_txn(DBG_RW, 1'b0, 12'h040, 32'h77, d, e, lat);
    dbg_txn(DBG_RD, 1'b1, 12'hFC0, 32'h0, d, e, lat);
    check_eq("wrap_data", d, 64'h0000_0077_0000_0055);
    check_eq("wrap_err", e, 1'b0);

    // reset while in LO drops the sequence silently
    dbg_issue(DBG_RD, 1'b1, 12'hC00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("lo_rst_ready", dbg_req_ready, 1'b0);
    check_eq("lo_rst_rsp_valid", dbg_rsp_valid, 1'b0);
    check_eq("lo_rst_ctrl", csr_ctrl, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("lo_rel_ready", dbg_req_ready, 1'b1);
    check_eq("lo_rel_rsp_valid", dbg_rsp_valid, 1'b0);
    check_eq("lo_rel_data", dbg_rsp_data, 64'h0);
    @(negedge clk);
    check_eq("lo_rel_no_rsp", dbg_rsp_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
